// File: rtl/riscv_id_pkg.sv
// ============================================================================
// riscv_id_pkg : shared RV32/RV64 base-ISA opcodes, class codes, imm fields
// Revision     : 1.0
// ============================================================================
`default_nettype none

package riscv_id_pkg;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_OP_IMM  = 4'd8,
        CLS_OP      = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_t;

    // Raw immediate fields; the caller sign-extends them to its datapath width.
    function automatic logic [11:0] fld_i(input logic [31:7] ins);
        return ins[31:20];
    endfunction

    function automatic logic [11:0] fld_s(input logic [31:7] ins);
        return {ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [12:0] fld_b(input logic [31:7] ins);
        return {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] fld_u(input logic [31:7] ins);
        return {ins[31:12], 12'b0};
    endfunction

    function automatic logic [20:0] fld_j(input logic [31:7] ins);
        return {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_imm_gen.sv
// ============================================================================
// riscv_imm_gen : I/S/B/U/J immediates, sign-extended from bit 31 to XLEN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module riscv_imm_gen
    import riscv_id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = XLEN'($signed(fld_i(instr)));
    assign imm_s = XLEN'($signed(fld_s(instr)));
    assign imm_b = XLEN'($signed(fld_b(instr)));
    assign imm_u = XLEN'($signed(fld_u(instr)));
    assign imm_j = XLEN'($signed(fld_j(instr)));

endmodule

`default_nettype wire

// File: rtl/riscv_id_pipe.sv
// ============================================================================
// riscv_id_pipe : registered RISC-V decode/operand-select stage with handshake
// Build option  : RISCV_ID_SKID_EN adds a skid entry and a registered in_ready
// Revision      : 1.0
// ============================================================================
`default_nettype none

module riscv_id_pipe
    import riscv_id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGN = 32,
    parameter int REGA = $clog2(REGN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic [REGA-1:0] rs1_addr,
    output logic [REGA-1:0] rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [REGA-1:0] rd,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] c,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      funct3,
    output logic            alt,
    output logic [3:0]      op_class,
    output logic            exception
);

    typedef struct packed {
        logic [REGA-1:0] rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] c;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic            alt;
        op_class_t       op_class;
        logic            exception;
    } bundle_t;

    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    bundle_t         w_dec;
    logic            w_use_rd, w_use_rs1, w_use_rs2;
    logic            w_bad_opc, w_bad_len, w_bad_reg, w_bad_shift, w_shift;
    logic            w_accept;

    bundle_t         r_out;
    logic            r_valid;

    riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instruction[31:7]),
        .imm_i (w_imm_i),
        .imm_s (w_imm_s),
        .imm_b (w_imm_b),
        .imm_u (w_imm_u),
        .imm_j (w_imm_j)
    );

    assign rs1_addr = instruction[15 +: REGA];
    assign rs2_addr = instruction[20 +: REGA];

    assign w_shift   = (instruction[13:12] == 2'b01);
    assign w_bad_len = (instruction[1:0] != 2'b11);
    // Indices are compared at 6 bits so REGN=32 does not wrap to zero.
    assign w_bad_reg = (w_use_rd  && ({1'b0, instruction[11:7]}  >= 6'(REGN)))
                    || (w_use_rs1 && ({1'b0, instruction[19:15]} >= 6'(REGN)))
                    || (w_use_rs2 && ({1'b0, instruction[24:20]} >= 6'(REGN)));
    assign w_bad_shift = (XLEN == 32) && (instruction[6:0] == c_opc_op_imm)
                      && w_shift && instruction[25];

    always_comb begin
        w_dec          = '0;
        w_dec.funct3   = instruction[14:12];
        w_dec.op_class = CLS_ILLEGAL;
        w_use_rd       = 1'b0;
        w_use_rs1      = 1'b0;
        w_use_rs2      = 1'b0;
        w_bad_opc      = 1'b0;
        case (instruction[6:0])
            c_opc_lui: begin
                w_dec.op_class = CLS_LUI;
                w_dec.a = w_imm_u;  w_dec.imm = w_imm_u;
                w_use_rd = 1'b1;
            end
            c_opc_auipc: begin
                w_dec.op_class = CLS_AUIPC;
                w_dec.a = pc;  w_dec.b = w_imm_u;  w_dec.imm = w_imm_u;
                w_use_rd = 1'b1;
            end
            c_opc_jal: begin
                w_dec.op_class = CLS_JAL;
                w_dec.a = pc;  w_dec.b = XLEN'(3'd4);  w_dec.imm = w_imm_j;
                w_use_rd = 1'b1;
            end
            c_opc_jalr: begin
                w_dec.op_class = CLS_JALR;
                w_dec.a = pc;  w_dec.b = XLEN'(3'd4);  w_dec.imm = w_imm_i;
                w_use_rd = 1'b1;  w_use_rs1 = 1'b1;
            end
            c_opc_op: begin
                w_dec.op_class = CLS_OP;
                w_dec.a = rs1_data;  w_dec.b = rs2_data;
                w_dec.alt = instruction[30];
                w_use_rd = 1'b1;  w_use_rs1 = 1'b1;  w_use_rs2 = 1'b1;
            end
            c_opc_op_imm: begin
                w_dec.op_class = CLS_OP_IMM;
                w_dec.a = rs1_data;  w_dec.b = w_imm_i;  w_dec.imm = w_imm_i;
                w_dec.alt = w_shift && instruction[30];
                w_use_rd = 1'b1;  w_use_rs1 = 1'b1;
            end
            c_opc_load: begin
                w_dec.op_class = CLS_LOAD;
                w_dec.a = rs1_data;  w_dec.b = w_imm_i;  w_dec.imm = w_imm_i;
                w_use_rd = 1'b1;  w_use_rs1 = 1'b1;
            end
            c_opc_store: begin
                w_dec.op_class = CLS_STORE;
                w_dec.a = rs1_data;  w_dec.b = w_imm_s;  w_dec.c = rs2_data;
                w_dec.imm = w_imm_s;
                w_use_rs1 = 1'b1;  w_use_rs2 = 1'b1;
            end
            c_opc_branch: begin
                w_dec.op_class = CLS_BRANCH;
                w_dec.a = rs1_data;  w_dec.b = rs2_data;  w_dec.c = rs2_data;
                w_dec.imm = w_imm_b;
                w_use_rs1 = 1'b1;  w_use_rs2 = 1'b1;
            end
            c_opc_system: begin
                w_dec.op_class = CLS_SYSTEM;
            end
            default: begin
                w_bad_opc = 1'b1;
            end
        endcase
        if (w_use_rd) begin
            w_dec.rd = instruction[7 +: REGA];
        end
        if (w_bad_opc || w_bad_len) begin
            w_dec.op_class = CLS_ILLEGAL;
        end
        // Trapping bundles still flow downstream, but carry no operands.
        if (w_bad_opc || w_bad_len || w_bad_reg || w_bad_shift
            || (instruction[6:0] == c_opc_system)) begin
            w_dec.exception = 1'b1;
            w_dec.a   = '0;
            w_dec.b   = '0;
            w_dec.c   = '0;
            w_dec.imm = '0;
            w_dec.rd  = '0;
        end
    end

    assign w_accept = in_valid && in_ready;

`ifdef RISCV_ID_SKID_EN
    bundle_t r_skid;
    logic    r_skid_valid;

    // in_ready depends only on state, so out_ready never reaches it.
    assign in_ready = rst_n && !flush && !r_skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (!r_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = rst_n && !flush && (!r_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (!r_valid || out_ready) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_dec;
            end
        end
    end
`endif

    assign out_valid = r_valid;
    assign rd        = r_out.rd;
    assign a         = r_out.a;
    assign b         = r_out.b;
    assign c         = r_out.c;
    assign imm       = r_out.imm;
    assign funct3    = r_out.funct3;
    assign alt       = r_out.alt;
    assign op_class  = r_out.op_class;
    assign exception = r_out.exception;

endmodule

`default_nettype wire

// File: tb/tb_riscv_id_pipe.sv
// ============================================================================
// tb_riscv_id_pipe : directed vectors for riscv_id_pipe (REGN=32 and REGN=16)
// Revision         : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_riscv_id_pipe;
    import riscv_id_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;

    logic        in_ready, out_valid, alt, exception;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [31:0] a, b, c, imm;
    logic [2:0]  funct3;
    logic [3:0]  op_class;

    logic        e_in_ready, e_out_valid, e_alt, e_exception;
    logic [3:0]  e_rs1_addr, e_rs2_addr, e_rd;
    logic [31:0] e_a, e_b, e_c, e_imm;
    logic [2:0]  e_funct3;
    logic [3:0]  e_op_class;

    int total = 0;
    int bad   = 0;

    riscv_id_pipe #(.XLEN(32), .REGN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
        .a(a), .b(b), .c(c), .imm(imm), .funct3(funct3), .alt(alt),
        .op_class(op_class), .exception(exception)
    );

    riscv_id_pipe #(.XLEN(32), .REGN(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
        .instruction(instruction), .pc(pc),
        .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(e_out_valid), .out_ready(out_ready), .rd(e_rd),
        .a(e_a), .b(e_b), .c(e_c), .imm(e_imm), .funct3(e_funct3), .alt(e_alt),
        .op_class(e_op_class), .exception(e_exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] d1, input logic [31:0] d2);
        in_valid    = 1'b1;
        instruction = ins;
        pc          = pcv;
        rs1_data    = d1;
        rs2_data    = d2;
        tick();
        in_valid    = 1'b0;
    endtask

    logic ir_trace [0:19];
    int   sent, recv;
    logic fire_in, fire_out;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_a", a, 0);
        check("rst_rd", rd, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("first_in_ready", in_ready, 1);

        // ADDI x1,x2,-1
        in_valid = 1'b1; instruction = 32'hFFF10093; rs1_data = 32'd5; #1;
        check("addi_rs1_addr", rs1_addr, 2);
        apply(32'hFFF10093, 32'h0, 32'd5, 32'd0);
        check("addi_valid", out_valid, 1);
        check("addi_a", a, 32'd5);
        check("addi_b", b, 32'hFFFFFFFF);
        check("addi_rd", rd, 1);
        check("addi_exc", exception, 0);
        check("addi_cls", op_class, CLS_OP_IMM);

        // BEQ x1,x2,-8
        apply(32'hFE208CE3, 32'h40, 32'd7, 32'd7);
        check("beq_a", a, 7);
        check("beq_b", b, 7);
        check("beq_c", c, 7);
        check("beq_imm", imm, 32'hFFFFFFF8);
        check("beq_rd", rd, 0);

        // Unlisted opcode 7'h7F
        apply(32'h0000007F, 32'h80, 32'h11, 32'h22);
        check("ill_valid", out_valid, 1);
        check("ill_exc", exception, 1);
        check("ill_a", a, 0);
        check("ill_b", b, 0);

        // ADD x17,x1,x2: legal at REGN=32, trap at REGN=16
        apply(32'h002088B3, 32'h0, 32'd3, 32'd9);
        check("add_exc32", exception, 0);
        check("add_a32", a, 3);
        check("add_b32", b, 9);
        check("add_rd32", rd, 17);
        check("add_exc16", e_exception, 1);
        check("add_rd16", e_rd, 0);
        check("add_a16", e_a, 0);

        // LUI x5,0x12345
        apply(32'h123452B7, 32'h0, 32'h55, 32'h66);
        check("lui_a", a, 32'h12345000);
        check("lui_b", b, 0);
        check("lui_rd", rd, 5);

        // AUIPC x3,0x80000
        apply(32'h80000197, 32'h100, 32'h0, 32'h0);
        check("auipc_a", a, 32'h100);
        check("auipc_b", b, 32'h80000000);

        // JAL x1,+8
        apply(32'h008000EF, 32'h200, 32'h0, 32'h0);
        check("jal_a", a, 32'h200);
        check("jal_b", b, 4);
        check("jal_imm", imm, 8);

        // SW x2,-4(x1)
        apply(32'hFE20AE23, 32'h0, 32'hA0, 32'hB0);
        check("sw_a", a, 32'hA0);
        check("sw_b", b, 32'hFFFFFFFC);
        check("sw_c", c, 32'hB0);
        check("sw_rd", rd, 0);
        check("sw_f3", funct3, 2);

        // SUB x3,x1,x2
        apply(32'h402081B3, 32'h0, 32'd10, 32'd4);
        check("sub_alt", alt, 1);

        // SLLI x1,x1,32 illegal at XLEN=32; ECALL; bad length bits
        apply(32'h02009093, 32'h0, 32'd1, 32'd0);
        check("slli32_exc", exception, 1);
        apply(32'h00000073, 32'h0, 32'd1, 32'd0);
        check("ecall_exc", exception, 1);
        check("ecall_rd", rd, 0);
        apply(32'hFFF10090, 32'h0, 32'd1, 32'd0);
        check("len_exc", exception, 1);

        tick();
        check("drain_empty", out_valid, 0);

        // Stalled stream of 4 ADDI xk,x0,k
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
            out_ready   = (cyc >= 3);
            in_valid    = (sent < 4);
            instruction = {12'(sent + 1), 5'd0, 3'b000, 5'(sent + 1), 7'h13};
            rs1_data    = 32'd0;
            #1;
            ir_trace[cyc] = in_ready;
            if (cyc == 1 || cyc == 2) begin
                check("stall_valid", out_valid, 1);
                check("stall_rd", rd, 1);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                check("order_rd", rd, 64'(recv + 1));
                check("order_b", b, 64'(recv + 1));
                recv++;
            end
            tick();
            if (fire_in) sent++;
        end
        in_valid = 1'b0;
        check("stream_count", recv, 4);
        check("ir_c0", ir_trace[0], 1);
`ifdef RISCV_ID_SKID_EN
        check("ir_c1", ir_trace[1], 1);
`else
        check("ir_c1", ir_trace[1], 0);
`endif
        check("ir_c2", ir_trace[2], 0);

        // Flush with held work and a simultaneous offer
        out_ready = 1'b0;
        apply(32'h00500293, 32'h0, 32'd0, 32'd0);
        apply(32'h00600313, 32'h0, 32'd0, 32'd0);
        check("pre_flush_valid", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        instruction = 32'h00700393;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        tick();
        check("flush_drain", out_valid, 0);

        // Asynchronous reset while stalled
        out_ready = 1'b0;
        apply(32'hFFF10093, 32'h0, 32'd5, 32'd0);
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_a", a, 0);
        check("arst_b", b, 0);
        check("arst_rd", rd, 0);
        check("arst_in_ready", in_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
